// File: rtl/seq_display_scheduler.sv
// Display scheduler for the sequence detector.
// Three requesters share one 7-segment display: a detection hit, an on-demand
// "show hit count" request, and idle. Hits take priority and restart their hold.
// A show request that arrives during a hit is remembered and served afterwards.
// A hit counter is shown in COUNT mode as one hex digit.
`timescale 1ns/1ps
module seq_display_scheduler #(
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_evt,
  input  logic             show_req,
  input  logic             clr_cnt,
  output logic             show_ack,
  output logic [7:0]       seg,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  localparam logic [7:0] SEG_IDLE = 8'h40;
  localparam logic [7:0] SEG_HIT  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIT   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            pend;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]      digit_next;

  // Hex digit to segment pattern, bit 0 = a .. bit 6 = g, dp off.
  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      4'hF: s = 8'h71;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Next hit count: clear wins over the old value, a same-cycle hit still counts.
  always_comb begin
    cnt_next = hit_cnt;
    if (clr_cnt) begin
      cnt_next = det_evt ? CNT_W'(1) : CNT_W'(0);
    end else if (det_evt) begin
      cnt_next = hit_cnt + CNT_W'(1);
    end else begin
      cnt_next = hit_cnt;
    end
    digit_next = 4'(cnt_next);
  end

  // Display FSM with hold timer, pending show request and registered outputs.
  // COUNT uses the next count so the shown digit always matches hit_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      pend     <= 1'b0;
      seg      <= SEG_IDLE;
      busy     <= 1'b0;
      show_ack <= 1'b0;
      hit_cnt  <= '0;
    end else begin
      hit_cnt  <= cnt_next;
      show_ack <= 1'b0;
      if (det_evt) begin
        state <= HIT;
        timer <= HOLD_LAST;
        pend  <= pend | show_req;
        seg   <= SEG_HIT;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (show_req || pend) begin
              state    <= COUNT;
              timer    <= HOLD_LAST;
              pend     <= 1'b0;
              show_ack <= 1'b1;
              seg      <= hex7(digit_next);
              busy     <= 1'b1;
            end else begin
              seg  <= SEG_IDLE;
              busy <= 1'b0;
            end
          end
          HIT: begin
            if (timer == '0) begin
              if (pend || show_req) begin
                state    <= COUNT;
                timer    <= HOLD_LAST;
                pend     <= 1'b0;
                show_ack <= 1'b1;
                seg      <= hex7(digit_next);
                busy     <= 1'b1;
              end else begin
                state <= IDLE;
                seg   <= SEG_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              timer <= timer - TW'(1);
              pend  <= pend | show_req;
            end
          end
          COUNT: begin
            // Show requests during COUNT are ignored; the digit tracks clears.
            if (timer == '0) begin
              state <= IDLE;
              seg   <= SEG_IDLE;
              busy  <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
              seg   <= hex7(digit_next);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
            pend  <= 1'b0;
            seg   <= SEG_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_display_scheduler.sv
// Self-checking bench for seq_display_scheduler with HOLD_CYCLES=4, CNT_W=4.
// A behavioural model tracks display mode, remaining hold cycles, the pending
// show request and the hit count, and predicts every output each cycle.
`timescale 1ns/1ps
module tb_seq_display_scheduler;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det_evt = 1'b0;
  logic       show_req = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       show_ack;
  logic [7:0] seg;
  logic       busy;
  logic [3:0] hit_cnt;

  int checks = 0;
  int fails  = 0;

  // model state: mode 0=idle 1=hit 2=count
  int m_mode = 0;
  int m_left = 0;
  bit m_pend = 1'b0;
  int m_cnt  = 0;
  bit m_ack  = 1'b0;

  logic [7:0] hex_tab [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seq_display_scheduler #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .det_evt  (det_evt),
    .show_req (show_req),
    .clr_cnt  (clr_cnt),
    .show_ack (show_ack),
    .seg      (seg),
    .busy     (busy),
    .hit_cnt  (hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec();
    logic [7:0] s;
    if (m_mode == 0) s = 8'h40;
    else if (m_mode == 1) s = 8'hFF;
    else s = hex_tab[m_cnt];
    return {s, (m_mode != 0), m_ack, 4'(m_cnt)};
  endfunction

  task automatic model_update(input bit d, input bit s, input bit c, input bit r);
    if (r) begin
      m_mode = 0; m_left = 0; m_pend = 0; m_cnt = 0; m_ack = 0;
    end else begin
      if (c) m_cnt = d ? 1 : 0;
      else   m_cnt = (m_cnt + int'(d)) % 16;
      m_ack = 0;
      if (d) begin
        m_mode = 1; m_left = HOLD; m_pend = m_pend | s;
      end else if (m_mode == 0) begin
        if (s || m_pend) begin
          m_mode = 2; m_left = HOLD; m_ack = 1; m_pend = 0;
        end
      end else begin
        if (m_mode == 1 && s) m_pend = 1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_pend) begin
            m_mode = 2; m_left = HOLD; m_ack = 1; m_pend = 0;
          end else begin
            m_mode = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic step(input bit d, input bit s, input bit c, input bit r);
    @(negedge clk);
    det_evt = d; show_req = s; clr_cnt = c; rst = r;
    @(posedge clk);
    model_update(d, s, c, r);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++;
    if ({seg, busy, show_ack, hit_cnt} !== {8'h40, 1'b0, 1'b0, 4'h0}) begin
      fails++;
      $display("FAIL reset: got seg=%h busy=%b ack=%b cnt=%h, want seg=40 busy=0 ack=0 cnt=0",
               seg, busy, show_ack, hit_cnt);
    end
  endtask

  task automatic test_single_hit();
    int ff_cycles = 0;
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    if (seg === 8'hFF) ff_cycles++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      if (seg === 8'hFF) ff_cycles++;
      checks++;
      if ({seg, busy, show_ack, hit_cnt} !== exp_vec()) begin
        fails++;
        $display("FAIL single_hit cyc%0d: got %h want %h", i, {seg, busy, show_ack, hit_cnt}, exp_vec());
      end
    end
    checks++;
    if (ff_cycles != 4 || seg !== 8'h40 || hit_cnt !== 4'h1) begin
      fails++;
      $display("FAIL single_hit_hold: got ff_cycles=%0d seg=%h cnt=%h, want 4 40 1", ff_cycles, seg, hit_cnt);
    end
  endtask

  task automatic test_retrigger();
    int ff_cycles = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(i == 0 || i == 2, 0, 0, 0);
      if (seg === 8'hFF) ff_cycles++;
      checks++;
      if ({seg, busy, show_ack, hit_cnt} !== exp_vec()) begin
        fails++;
        $display("FAIL retrigger cyc%0d: got %h want %h", i, {seg, busy, show_ack, hit_cnt}, exp_vec());
      end
    end
    checks++;
    if (ff_cycles != 6 || seg !== 8'h40 || hit_cnt !== 4'h2) begin
      fails++;
      $display("FAIL retrigger_hold: got ff_cycles=%0d seg=%h cnt=%h, want 6 40 2", ff_cycles, seg, hit_cnt);
    end
  endtask

  task automatic test_pending_show();
    int acks = 0;
    int count_cycles = 0;
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, i == 1, 0, 0);
      if (show_ack === 1'b1) acks++;
      if (seg === 8'h5B) count_cycles++;
      checks++;
      if ({seg, busy, show_ack, hit_cnt} !== exp_vec()) begin
        fails++;
        $display("FAIL pending_show cyc%0d: got %h want %h", i, {seg, busy, show_ack, hit_cnt}, exp_vec());
      end
    end
    checks++;
    if (acks != 1 || count_cycles != 4 || seg !== 8'h40) begin
      fails++;
      $display("FAIL pending_show_count: got acks=%0d count_cycles=%0d seg=%h, want 1 4 40",
               acks, count_cycles, seg);
    end
  endtask

  task automatic test_wrap_preempt();
    step(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if ({seg, show_ack, hit_cnt} !== {8'h06, 1'b1, 4'h1} || {seg, busy, show_ack, hit_cnt} !== exp_vec()) begin
      fails++;
      $display("FAIL wrap_count: got seg=%h ack=%b cnt=%h, want seg=06 ack=1 cnt=1", seg, show_ack, hit_cnt);
    end
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if ({seg, busy, hit_cnt} !== {8'hFF, 1'b1, 4'h2}) begin
      fails++;
      $display("FAIL preempt_count: got seg=%h busy=%b cnt=%h, want FF 1 2", seg, busy, hit_cnt);
    end
  endtask

  task automatic test_clr_and_abort();
    int acks = 0;
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    checks++;
    if (hit_cnt !== 4'h1) begin
      fails++;
      $display("FAIL clr_with_det: got cnt=%h, want 1", hit_cnt);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if ({seg, busy, show_ack, hit_cnt} !== {8'h40, 1'b0, 1'b0, 4'h0}) begin
      fails++;
      $display("FAIL abort_reset: got seg=%h busy=%b ack=%b cnt=%h, want 40 0 0 0", seg, busy, show_ack, hit_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (show_ack === 1'b1 || seg !== 8'h40) acks++;
    end
    checks++;
    if (acks != 0) begin
      fails++;
      $display("FAIL pend_dropped: got %0d non-idle cycles after reset, want 0", acks);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(5) == 0, $urandom_range(4) == 0, $urandom_range(11) == 0,
           $urandom_range(59) == 0);
      checks++;
      if ({seg, busy, show_ack, hit_cnt} !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc%0d: got seg=%h busy=%b ack=%b cnt=%h want %h",
                 i, seg, busy, show_ack, hit_cnt, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_retrigger();
    test_pending_show();
    test_wrap_preempt();
    test_clr_and_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
